// File: rtl/free_list_pkg.sv
// Shared rename-stage sizing and index types, used by the free list, map table and ROB.
package free_list_pkg;
  localparam int PKG_AREG_WIDTH = 5;
  localparam int PKG_PREG_WIDTH = 7;
  localparam int PKG_ROB_WIDTH  = 4;

  localparam int NUM_AREGS = 1 << PKG_AREG_WIDTH;
  localparam int NUM_PREGS = 1 << PKG_PREG_WIDTH;
  localparam int NUM_CKPTS = 1 << PKG_ROB_WIDTH;

  typedef logic [PKG_PREG_WIDTH-1:0] preg_t;
  typedef logic [PKG_PREG_WIDTH:0]   ptr_t;
  typedef logic [PKG_ROB_WIDTH-1:0]  rob_tag_t;
endpackage

// File: rtl/free_list.sv
// Circular-buffer physical register free list with per-branch head checkpoints
// for single-cycle mispredict recovery.
module free_list
  import free_list_pkg::*;
#(
  parameter int AREG_WIDTH = PKG_AREG_WIDTH,
  parameter int PREG_WIDTH = PKG_PREG_WIDTH,
  parameter int ROB_WIDTH  = PKG_ROB_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  output logic                  alloc_valid,
  output logic [PREG_WIDTH-1:0] alloc_preg,
  input  logic                  free_valid,
  input  logic [PREG_WIDTH-1:0] free_preg,
  input  logic                  is_branch_dispatch,
  input  logic [ROB_WIDTH-1:0]  dispatch_tag,
  input  logic                  branch_mispredict,
  input  logic [ROB_WIDTH-1:0]  recovery_tag,
  output logic [PREG_WIDTH:0]   free_count,
  output logic                  overflow_err
);
  localparam int NP = 1 << PREG_WIDTH;
  localparam int NA = 1 << AREG_WIDTH;
  localparam int NC = 1 << ROB_WIDTH;

  logic [PREG_WIDTH-1:0] r_buf  [NP];
  logic [PREG_WIDTH:0]   r_ckpt [NC];
  logic [PREG_WIDTH:0]   r_head, r_tail;
  logic                  r_ovf;

  logic                  w_empty, w_full, w_alloc, w_free, w_free_drop;
  logic [PREG_WIDTH:0]   w_head_post;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  always_comb begin
    w_empty     = (r_head == r_tail);
    w_full      = (r_head[PREG_WIDTH-1:0] == r_tail[PREG_WIDTH-1:0]) &&
                  (r_head[PREG_WIDTH] != r_tail[PREG_WIDTH]);
    w_alloc     = alloc_req && !w_empty && !branch_mispredict;
    w_free      = free_valid && (free_preg != '0) && !w_full;
    w_free_drop = free_valid && (free_preg != '0) && w_full;
    w_head_post = r_head + {{PREG_WIDTH{1'b0}}, w_alloc};
  end

  assign alloc_valid  = !w_empty;
  assign alloc_preg   = r_buf[r_head[PREG_WIDTH-1:0]];
  assign free_count   = r_tail - r_head;
  assign overflow_err = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NP; i++)
        r_buf[i] <= (i < NP - NA) ? PREG_WIDTH'(i + NA) : '0;
      for (int i = 0; i < NC; i++)
        r_ckpt[i] <= '0;
      r_head <= '0;
      r_tail <= (PREG_WIDTH+1)'(NP - NA);
      r_ovf  <= 1'b0;
    end else begin
      if (w_free) begin
        r_buf[r_tail[PREG_WIDTH-1:0]] <= free_preg;
        r_tail <= r_tail + 1'b1;
      end
      if (w_free_drop)
        r_ovf <= 1'b1;
      // Tail is never rolled back: commits are older than any in-flight branch.
      if (branch_mispredict) begin
        r_head <= r_ckpt[recovery_tag];
      end else begin
        r_head <= w_head_post;
        if (is_branch_dispatch)
          r_ckpt[dispatch_tag] <= w_head_post;
      end
    end
  end
endmodule

// File: tb/tb_free_list.sv
// Randomized + directed scoreboard bench for free_list against a queue-based reference model.
module tb_free_list;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_valid;
  logic [6:0] alloc_preg;
  logic       free_valid = 1'b0;
  logic [6:0] free_preg = '0;
  logic       is_branch_dispatch = 1'b0;
  logic [3:0] dispatch_tag = '0;
  logic       branch_mispredict = 1'b0;
  logic [3:0] recovery_tag = '0;
  logic [7:0] free_count;
  logic       overflow_err;

  free_list dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_preg(alloc_preg), .free_valid(free_valid), .free_preg(free_preg),
    .is_branch_dispatch(is_branch_dispatch), .dispatch_tag(dispatch_tag),
    .branch_mispredict(branch_mispredict), .recovery_tag(recovery_tag),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int p; int cnt; bit ovf; } exp_t;
  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: free pregs in order, plus the history of granted pregs
  // so a checkpoint is just "how many grants had happened".
  int   fl[$];
  int   popped[$];
  int   ck[16];
  bit   ckv[16];
  bit   movf;

  task automatic step(input bit rst, input bit ar, input bit fv, input int fp,
                      input bit bd, input int dt, input bit bm, input int rt);
    exp_t e;
    bit g, fr;
    int c;
    @(negedge clk);
    reset = rst; alloc_req = ar; free_valid = fv; free_preg = 7'(fp);
    is_branch_dispatch = bd; dispatch_tag = 4'(dt);
    branch_mispredict = bm; recovery_tag = 4'(rt);
    if (rst) begin
      fl.delete(); popped.delete();
      for (int i = 32; i < 128; i++) fl.push_back(i);
      for (int i = 0; i < 16; i++) begin ck[i] = 0; ckv[i] = 0; end
      movf = 0;
    end else begin
      g  = ar && fl.size() > 0 && !bm;
      fr = fv && fp != 0 && fl.size() < 128;
      if (fv && fp != 0 && fl.size() == 128) movf = 1;
      if (bm) begin
        c = ck[rt];
        while (popped.size() > c) fl.push_front(popped.pop_back());
        for (int i = 0; i < 16; i++) if (ckv[i] && ck[i] > c) ckv[i] = 0;
      end
      if (g) popped.push_back(fl.pop_front());
      if (bd && !bm) begin ck[dt] = popped.size(); ckv[dt] = 1; end
      if (fr) fl.push_back(fp);
    end
    e.v = fl.size() > 0; e.p = e.v ? fl[0] : 0; e.cnt = fl.size(); e.ovf = movf;
    @(posedge clk);
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle with a pending expectation, compare the DUT's outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (alloc_valid !== e.v) begin
          miscompares++;
          $display("FAIL alloc_valid got %0b want %0b @%0t", alloc_valid, e.v, $time);
        end
        if (e.v) begin
          vectors++;
          if (int'(alloc_preg) != e.p || $isunknown(alloc_preg)) begin
            miscompares++;
            $display("FAIL alloc_preg got %0d want %0d @%0t", alloc_preg, e.p, $time);
          end
        end
        vectors++;
        if (int'(free_count) != e.cnt || $isunknown(free_count)) begin
          miscompares++;
          $display("FAIL free_count got %0d want %0d @%0t", free_count, e.cnt, $time);
        end
        vectors++;
        if (overflow_err !== e.ovf) begin
          miscompares++;
          $display("FAIL overflow_err got %0b want %0b @%0t", overflow_err, e.ovf, $time);
        end
      end
    end
  end

  initial begin
    int minc, t;
    bit ar, fv, bd, bm;
    int fp;
    // Drain from reset; a 97th request on an empty list changes nothing.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 97; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    // Empty: same-cycle free p40 and alloc, no bypass.
    step(0, 1, 1, 40, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    // Checkpoint / recovery sequence.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 5, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 5);
    // Mispredict concurrent with free p7 and alloc.
    step(0, 1, 0, 0, 1, 2, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 7, 1, 9, 1, 2);
    // p0 free is ignored.
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // Fill to full, then overflow is sticky until reset.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 32; i++) step(0, 0, 1, i, 0, 0, 0, 0);
    step(0, 0, 1, 50, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Wrap: 300 alloc/free pairs recycling the granted preg.
    for (int i = 0; i < 300; i++) step(0, 1, 1, fl[0], 0, 0, 0, 0);
    // Random traffic with realistic checkpoint lifetimes.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 16; k++)
        if (ckv[k] && ck[k] + 40 < popped.size()) ckv[k] = 0;
      minc = popped.size();
      for (int k = 0; k < 16; k++) if (ckv[k] && ck[k] < minc) minc = ck[k];
      ar = ($urandom_range(99) < 60);
      fv = ($urandom_range(99) < 45) && (fl.size() + popped.size() - minc < 120);
      fp = $urandom_range(127);
      bd = ($urandom_range(99) < 15);
      t  = $urandom_range(15);
      bm = ($urandom_range(99) < 6) && ckv[t];
      step(0, ar, fv, fp, bd, $urandom_range(15), bm, t);
    end
    idle();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage. Supplies an unused physical register (`alloc_preg`) to the map table each time a renamed instruction writes `rd`. Accepts retired physical registers back from ROB commit. Checkpoints its allocation pointer per branch ROB tag so that a mispredict returns every register allocated after the branch in one cycle.

## Interface
- `AREG_WIDTH`, default 5: architectural register index width; the first `2^AREG_WIDTH` pregs are initially mapped and never on the list at reset.
- `PREG_WIDTH`, default 7: physical register index width; `NUM_PREGS = 2^PREG_WIDTH`.
- `ROB_WIDTH`, default 4: branch/ROB tag width; `2^ROB_WIDTH` checkpoints.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `alloc_req`  in  1  rename consumes `alloc_preg` this cycle (instruction has `reg_write` and `rd != 0`).
- `alloc_valid`  out  1  list non-empty; `alloc_preg` is usable.
- `alloc_preg`  out  PREG_WIDTH  preg at head of list (combinational from head).
- `free_valid`  in  1  commit returns a preg.
- `free_preg`  in  PREG_WIDTH  preg being returned (ROB's stored `old_p_dest`).
- `is_branch_dispatch`  in  1  checkpoint head pointer this cycle.
- `dispatch_tag`  in  ROB_WIDTH  checkpoint slot to write.
- `branch_mispredict`  in  1  restore head pointer.
- `recovery_tag`  in  ROB_WIDTH  checkpoint slot to read.
- `free_count`  out  PREG_WIDTH+1  number of free pregs.
- `overflow_err`  out  1  sticky; set on a free into a full list.

## Operation
- Storage is a circular buffer with `NUM_PREGS` entries of PREG_WIDTH bits.
- `head` and `tail` are PREG_WIDTH+1 bits; the MSB is the wrap bit.
- Empty when `head == tail`. Full when the index bits are equal and the wrap bits differ.
- `free_count = tail - head`, modulo `2^(PREG_WIDTH+1)`.
- Reset:
  - `buf[i] = i + 2^AREG_WIDTH` for `i < NUM_PREGS - 2^AREG_WIDTH`.
  - `head = 0`, `tail = NUM_PREGS - 2^AREG_WIDTH`.
  - Checkpoints are all zero.
  - `overflow_err = 0`.
- Reset outputs at default parameters: `alloc_valid = 1`, `alloc_preg = 32`, `free_count = 96`.
- Allocate: `alloc_req && alloc_valid && !branch_mispredict` advances `head` by 1. `alloc_req` while empty is ignored; rename must stall on `!alloc_valid`.
- Free: `free_valid && free_preg != 0 && !full` writes `buf[tail]` and advances `tail`.
  - `free_preg == 0` is ignored (p0 is permanently x0).
  - Free while full is dropped and sets `overflow_err`.
- Checkpoint: on `is_branch_dispatch && !branch_mispredict`, `ckpt[dispatch_tag]` takes the post-allocation head, i.e. it includes this cycle's allocation. This matches the map-table snapshot, which reflects post-rename state.
- Recovery: on `branch_mispredict`, `head <= ckpt[recovery_tag]`. `tail` is never restored, because commits are in order and older than the branch.
- Priorities within one cycle:
  - Mispredict beats alloc and checkpoint.
  - Free is independent and always processed, including during a mispredict.
  - Alloc and free in the same cycle are both processed. There is no bypass: when the list is empty, a same-cycle freed preg is not allocatable until the next cycle.

## Timing
- `alloc_preg`, `alloc_valid` and `free_count` are combinational from registered state, with zero-cycle read latency.
- Allocation, free, checkpoint and recovery take effect at the clock edge; outputs reflect them the following cycle.
- Recovery is single-cycle. The cycle after `branch_mispredict`, `alloc_preg` equals the entry at the restored head.
- Reset mid-operation restores the full reset image in one cycle, discarding in-flight state.
- Pointers wrap naturally at `2^(PREG_WIDTH+1)`. There is no special case at index `NUM_PREGS-1`.

## Structure
- The shared rename package holds:
  - `NUM_AREGS`, `NUM_PREGS`, `NUM_CKPTS`.
  - `preg_t` (PREG_WIDTH), `ptr_t` (PREG_WIDTH+1), `rob_tag_t` (ROB_WIDTH).
- The package is shared with the map table and ROB.
- Single module, no sub-modules. The checkpoint array (`NUM_CKPTS` × `ptr_t`) is inline.
- Full/empty/count logic is a small combinational block inside the module.

## Test plan
- Reset, then 96 consecutive `alloc_req`:
  - Returns pregs 32..127 in order.
  - `alloc_valid` drops after the 96th; `free_count = 0`.
  - A 97th `alloc_req` leaves state unchanged.
- From empty, free p40 and alloc in the same cycle:
  - No grant that cycle.
  - Next cycle `alloc_valid = 1`, `alloc_preg = 40`.
- Reset; alloc 3 (32, 33, 34). Then alloc 35 with `is_branch_dispatch`, tag 5. Then alloc 36 and 37. Then `branch_mispredict` with tag 5:
  - `alloc_preg = 36` next cycle.
  - `free_count = 92`.
- Mispredict concurrent with `free_valid` (p7) and `alloc_req`:
  - Head restored.
  - p7 appended at tail.
  - No allocation.
  - `free_count` = restored count + 1.
- Free p0: ignored, count unchanged. Free into a full list (after reset plus 32 frees): `overflow_err = 1` and stays set until reset.
- Wrap: cycle 300 alloc/free pairs.
  - FIFO order is preserved across pointer wrap.
  - `free_count` stays constant.
